pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus for pc_sequencer.
//   master : drives the core enable, the fetch strobe, the current instruction,
//            the rs value and the redirect decode; it reads back the PC and status.
//   slave  : the sequencer itself.
interface pc_sequencer_if;
  logic        active;
  logic        fetch;
  logic [31:0] instruction;
  logic [31:0] reg_data;
  logic        jcontrol;
  logic        jrcontrol;
  logic        bcontrol;
  logic        link;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        halted;
  logic        slot_error;

  modport master (
    output active, fetch, instruction, reg_data, jcontrol, jrcontrol, bcontrol, link,
    input  pc_out, link_addr, in_delay_slot, halted, slot_error
  );

  modport slave (
    input  active, fetch, instruction, reg_data, jcontrol, jrcontrol, bcontrol, link,
    output pc_out, link_addr, in_delay_slot, halted, slot_error
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer for a MIPS-style core.
// The PC advances on edges where active and fetch are both high. It redirects
// on J, JR or branch, with an optional one-instruction delay slot. It halts
// when a redirect lands on HALT_ADDR.
//   clk, reset : single clock; synchronous active-high reset
//   bus        : pc_sequencer_if.slave
//                inputs  : active, fetch, instruction, reg_data, j/jr/bcontrol, link
//                outputs : pc_out, link_addr, in_delay_slot, halted, slot_error
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned DELAY_SLOT   = 1,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {RUN = 2'd0, DELAY = 2'd1, HALT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        serr_q, serr_d;
  logic        ids_q, ids_d;
  logic        halted_q, halted_d;

  logic [31:0] seq, j_tgt, br_tgt, tgt;
  logic        adv, redirect;

  assign adv      = bus.active & bus.fetch;
  assign redirect = bus.jrcontrol | bus.jcontrol | bus.bcontrol;
  assign seq      = pc_q + 32'd4;
  assign j_tgt    = {seq[31:28], bus.instruction[25:0], 2'b00};
  assign br_tgt   = seq + {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};

  // Priority among the redirect types: jr, then j, then branch.
  always_comb begin
    if (bus.jrcontrol)     tgt = bus.reg_data;
    else if (bus.jcontrol) tgt = j_tgt;
    else                   tgt = br_tgt;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    serr_d  = serr_q;
    case (state_q)
      RUN: begin
        if (adv) begin
          if (redirect && DELAY_SLOT != 0) begin
            pc_d    = seq;
            pend_d  = tgt;
            state_d = DELAY;
          end else if (redirect) begin
            pc_d    = tgt;
            state_d = (tgt == HALT_ADDR) ? HALT : RUN;
          end else begin
            // Falling through onto HALT_ADDR is not a halt; only a redirect halts.
            pc_d    = seq;
          end
        end
      end
      DELAY: begin
        if (adv) begin
          // A redirect in the delay slot is dropped and flagged.
          if (redirect) serr_d = 1'b1;
          pc_d    = pend_q;
          state_d = (pend_q == HALT_ADDR) ? HALT : RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    ids_d    = (state_d == DELAY);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      pend_q   <= 32'd0;
      serr_q   <= 1'b0;
      ids_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      serr_q   <= serr_d;
      ids_q    <= ids_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.link_addr     = pc_q + 32'd8;
  assign bus.in_delay_slot = ids_q;
  assign bus.halted        = halted_q;
  assign bus.slot_error    = serr_q;

  // The opcode bits are decoded elsewhere. link only matters to whoever consumes link_addr.
  logic unused_bits;
  assign unused_bits = ^{bus.instruction[31:26], bus.link};

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst1, rst0;
  always #5 clk = ~clk;

  pc_sequencer_if b1 ();
  pc_sequencer_if b0 ();

  pc_sequencer #(.DELAY_SLOT(1)) u_dut  (.clk(clk), .reset(rst1), .bus(b1.slave));
  pc_sequencer #(.DELAY_SLOT(0)) u_dut0 (.clk(clk), .reset(rst0), .bus(b0.slave));

  typedef struct {
    logic        rst, act, fet;
    logic [31:0] instr, rd;
    logic        jr, j, br, lnk;
    logic [31:0] pc;
    logic        ids, hlt, serr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl1[$];
  vec_t tbl0[$];

  function automatic vec_t mk(input logic rst, act, fet, input logic [31:0] instr, rd,
                              input logic jr, j, br, lnk, input logic [31:0] pc,
                              input logic ids, hlt, serr);
    vec_t v;
    v.rst = rst; v.act = act; v.fet = fet; v.instr = instr; v.rd = rd;
    v.jr = jr; v.j = j; v.br = br; v.lnk = lnk;
    v.pc = pc; v.ids = ids; v.hlt = hlt; v.serr = serr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int sel, input vec_t v, input int idx);
    if (sel == 1) begin
      rst1 = v.rst; b1.active = v.act; b1.fetch = v.fet; b1.instruction = v.instr;
      b1.reg_data = v.rd; b1.jrcontrol = v.jr; b1.jcontrol = v.j; b1.bcontrol = v.br;
      b1.link = v.lnk;
    end else begin
      rst0 = v.rst; b0.active = v.act; b0.fetch = v.fet; b0.instruction = v.instr;
      b0.reg_data = v.rd; b0.jrcontrol = v.jr; b0.jcontrol = v.j; b0.bcontrol = v.br;
      b0.link = v.lnk;
    end
    @(posedge clk);
    #1;
    if (sel == 1) begin
      chk("ds1_pc", idx, b1.pc_out, v.pc);
      chk("ds1_link_addr", idx, b1.link_addr, v.pc + 32'd8);
      chk("ds1_in_delay_slot", idx, {31'd0, b1.in_delay_slot}, {31'd0, v.ids});
      chk("ds1_halted", idx, {31'd0, b1.halted}, {31'd0, v.hlt});
      chk("ds1_slot_error", idx, {31'd0, b1.slot_error}, {31'd0, v.serr});
    end else begin
      chk("ds0_pc", idx, b0.pc_out, v.pc);
      chk("ds0_link_addr", idx, b0.link_addr, v.pc + 32'd8);
      chk("ds0_in_delay_slot", idx, {31'd0, b0.in_delay_slot}, {31'd0, v.ids});
      chk("ds0_halted", idx, {31'd0, b0.halted}, {31'd0, v.hlt});
      chk("ds0_slot_error", idx, {31'd0, b0.slot_error}, {31'd0, v.serr});
    end
  endtask

  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    b1.active = 0; b1.fetch = 0; b1.instruction = 0; b1.reg_data = 0;
    b1.jrcontrol = 0; b1.jcontrol = 0; b1.bcontrol = 0; b1.link = 0;
    b0.active = 0; b0.fetch = 0; b0.instruction = 0; b0.reg_data = 0;
    b0.jrcontrol = 0; b0.jcontrol = 0; b0.bcontrol = 0; b0.link = 0;

    //                    rst a f  instr         rd            jr j b l  pc            ids h s
    tbl1.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00004, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00008, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC0000C, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00010, 0, 0, 0));
    // backward branch by -8 from the sequential address
    tbl1.push_back(mk(0, 1, 1, 32'h0000FFFE, 32'h0,        0, 0, 1, 0, 32'hBFC00014, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC0000C, 0, 0, 0));
    tbl1.push_back(mk(0, 0, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC0000C, 0, 0, 0));
    // linking branch forward +16, then three stalled cycles in DELAY
    tbl1.push_back(mk(0, 1, 1, 32'h00000004, 32'h0,        0, 0, 1, 1, 32'hBFC00010, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00010, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 0, 32'h00000100, 32'h0,        0, 1, 0, 0, 32'hBFC00010, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00010, 1, 0, 0));
    // jump in the delay slot: ignored, sticky slot_error
    tbl1.push_back(mk(0, 1, 1, 32'h00000100, 32'h0,        0, 1, 0, 0, 32'hBFC00020, 0, 0, 1));
    tbl1.push_back(mk(1, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    // jr to HALT_ADDR
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        1, 0, 0, 0, 32'hBFC00004, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00000000, 0, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl1.push_back(mk(0, 1, 1, 32'h00000100, 32'h40,     1, 1, 1, 0, 32'h00000000, 0, 1, 0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    // all three redirects: jr wins, low bits of reg_data kept
    tbl1.push_back(mk(0, 1, 1, 32'h00000010, 32'h12345679, 1, 1, 1, 0, 32'hBFC00004, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h12345679, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h1234567D, 0, 0, 0));
    // j beats branch
    tbl1.push_back(mk(0, 1, 1, 32'h03FFFFFF, 32'h0,        0, 1, 1, 0, 32'h12345681, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h1FFFFFFC, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h20000000, 0, 0, 0));
    // walk sequentially across 0xFFFFFFFC -> 0x0: wraps, no halt
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'hFFFFFFF8, 1, 0, 0, 0, 32'h20000004, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hFFFFFFF8, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00000000, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00000004, 0, 0, 0));
    // reset while in DELAY drops the pending target
    tbl1.push_back(mk(0, 1, 1, 32'h00000010, 32'h0,        0, 0, 1, 0, 32'h00000008, 1, 0, 0));
    tbl1.push_back(mk(1, 1, 1, 32'h0,        32'h0,        1, 1, 1, 0, 32'hBFC00000, 0, 0, 0));
    tbl1.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00004, 0, 0, 0));

    // no delay slot
    tbl0.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h00000100, 32'h0,        0, 1, 0, 0, 32'hB0000400, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hB0000404, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h0000FFFF, 32'h0,        0, 0, 1, 0, 32'hB0000404, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h00000100, 32'h0,        1, 1, 0, 0, 32'h00000000, 0, 1, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h00000100, 32'h0,        0, 1, 0, 0, 32'h00000000, 0, 1, 0));
    tbl0.push_back(mk(1, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'hBFC00004, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h0,        32'hFFFFFFFC, 1, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 0));
    tbl0.push_back(mk(0, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00000000, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl1.size(); i++) apply(1, tbl1[i], i);
    for (int i = 0; i < tbl0.size(); i++) apply(0, tbl0[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
